// File: rtl/trng_com_pkg.sv
// Shared definitions for the trng_com serial transmitter and receiver.
// Holds the RX state encoding, the 8N1 frame constants and a width helper.
package trng_com_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/trng_sync.sv
// Multi-flop synchroniser for an asynchronous level; resets to 1 (idle line).
module trng_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/trng_com_rx.sv
// 8N1 serial receiver with valid/read handshake and RTS flow control.
// A byte completed while the previous one is unread is dropped and flagged.
module trng_com_rx
    import trng_com_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_serial_data,
    input  logic                 i_read,
    output logic [DATA_BITS-1:0] o_dat,
    output logic                 o_valid,
    output logic                 o_serial_rts_n,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_new_frame
);

    localparam int unsigned TIMER_W = clog2(CLKS_PER_BIT);
    localparam int unsigned INDEX_W = clog2(DATA_BITS);

    localparam logic [TIMER_W-1:0] SAMPLE_MID   = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] SAMPLE_START = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [INDEX_W-1:0] LAST_INDEX   = INDEX_W'(DATA_BITS - 1);

    logic                 rx;
    logic                 prev_rx;
    rx_state_t            state,     state_nxt;
    logic [TIMER_W-1:0]   timer,     timer_nxt;
    logic [INDEX_W-1:0]   index,     index_nxt;
    logic [DATA_BITS-1:0] shift,     shift_nxt;
    logic                 stop_ok,   stop_ok_nxt;
    logic                 frame_err_nxt;
    logic [DATA_BITS-1:0] dat_nxt;
    logic                 valid_nxt;
    logic                 overrun_nxt;
    logic                 new_frame_nxt;

    trng_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_serial_data),
        .o_q     (rx)
    );

    // State, datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= RX_IDLE;
            timer          <= '0;
            index          <= '0;
            shift          <= '0;
            stop_ok        <= 1'b0;
            prev_rx        <= 1'b1;
            o_dat          <= '0;
            o_valid        <= 1'b0;
            o_serial_rts_n <= 1'b0;
            o_frame_err    <= 1'b0;
            o_overrun      <= 1'b0;
            o_new_frame    <= 1'b0;
        end else begin
            state          <= state_nxt;
            timer          <= timer_nxt;
            index          <= index_nxt;
            shift          <= shift_nxt;
            stop_ok        <= stop_ok_nxt;
            prev_rx        <= rx;
            o_dat          <= dat_nxt;
            o_valid        <= valid_nxt;
            o_serial_rts_n <= valid_nxt;
            o_frame_err    <= frame_err_nxt;
            o_overrun      <= overrun_nxt;
            o_new_frame    <= new_frame_nxt;
        end
    end

    // Frame sequencing, delivery and read handling
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        index_nxt     = index;
        shift_nxt     = shift;
        stop_ok_nxt   = 1'b0;
        frame_err_nxt = 1'b0;
        dat_nxt       = o_dat;
        valid_nxt     = o_valid;
        overrun_nxt   = 1'b0;
        new_frame_nxt = 1'b0;

        case (state)
            RX_IDLE: begin
                timer_nxt = '0;
                index_nxt = '0;
                // Only an edge starts a frame, so a held-low break is ignored
                if (prev_rx && !rx) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (timer == SAMPLE_START) begin
                    timer_nxt = '0;
                    index_nxt = '0;
                    state_nxt = rx ? RX_IDLE : RX_DATA;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            RX_DATA: begin
                if (timer == SAMPLE_MID) begin
                    timer_nxt = '0;
                    shift_nxt = {rx, shift[DATA_BITS-1:1]};
                    if (index == LAST_INDEX) begin
                        index_nxt = '0;
                        state_nxt = RX_STOP;
                    end else begin
                        index_nxt = index + INDEX_W'(1);
                    end
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            RX_STOP: begin
                if (timer == SAMPLE_MID) begin
                    timer_nxt     = '0;
                    state_nxt     = RX_IDLE;
                    stop_ok_nxt   = rx;
                    frame_err_nxt = !rx;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            default: begin
                state_nxt = RX_IDLE;
                timer_nxt = '0;
                index_nxt = '0;
            end
        endcase

        // A read in the delivery cycle frees the slot for the new byte
        if (stop_ok) begin
            if (!o_valid || i_read) begin
                dat_nxt       = shift;
                valid_nxt     = 1'b1;
                new_frame_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (i_read) begin
            valid_nxt = 1'b0;
        end
    end

endmodule

// File: doc/trng_com_rx.md
Name: trng_com_rx

Overview:
- Serial 8N1 receiver. It is the host-to-board counterpart of the trng_com transmitter.
- It deserialises bytes arriving on the board's serial RX pin and presents them on a valid/read handshake.
- It drives an active-low RTS line so the host pauses while a received byte is still unread.
- Intended consumer: a command decoder, e.g. for dump trigger or periodic-reset config, alongside trng_top.

Parameters:
- CLKS_PER_BIT, 104: i_clk cycles per serial bit; minimum 4.
- SYNC_STAGES, 2: flops in the input synchroniser on i_serial_data; minimum 2.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_serial_data  in  1  asynchronous serial RX line; idle high.
- i_read  in  1  consumer takes o_dat; effective only when o_valid=1.
- o_dat  out  8  received byte, stable while o_valid=1.
- o_valid  out  1  o_dat holds an unread byte.
- o_serial_rts_n  out  1  0 = host may send, 1 = host must pause.
- o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- o_overrun  out  1  one-cycle pulse when a good byte is dropped because o_dat is unread.
- o_new_frame  out  1  one-cycle pulse when a byte is loaded into o_dat.

Behaviour:
- Reset values:
  - o_dat=0, o_valid=0, o_serial_rts_n=0, all pulse outputs 0.
  - State=IDLE, bit timer=0, bit index=0.
  - Synchroniser flops and the previous-sample flop are all set to 1.
- Synchroniser: i_serial_data passes through SYNC_STAGES flops; "rx" is the last stage. A prev_rx flop holds rx delayed by one cycle.
- Bit timer width is clog2(CLKS_PER_BIT). The timer resets to 0 on every state change and at every sample point.
- Sample point (mid-bit) is timer == CLKS_PER_BIT-1.
- FSM:
  - IDLE: when prev_rx=1 and rx=0 (falling edge), go to START with timer=0. A low level without an edge (break condition) never starts a frame.
  - START: at timer == CLKS_PER_BIT/2-1 (integer division), sample rx.
    - rx=1: glitch, return to IDLE with no pulses.
    - rx=0: go to DATA, timer=0, index=0.
  - DATA: at each sample point, shift rx in LSB-first and increment index. After the sample with index==7, go to STOP.
  - STOP: at the sample point:
    - rx=1: deliver the byte (see below).
    - rx=0: pulse o_frame_err and discard the byte.
    - Either way, return to IDLE.
- Delivery, on the cycle after a good stop sample:
  - If o_valid=0, or i_read=1 in that same cycle: o_dat <= shift register, o_valid <= 1, pulse o_new_frame.
  - Otherwise: o_dat and o_valid are unchanged and o_overrun pulses.
- Read: i_read with o_valid=1 clears o_valid next cycle, unless a delivery happens in that same cycle (then o_valid stays 1 with the new byte). i_read with o_valid=0 is ignored.
- RTS: o_serial_rts_n = o_valid, registered, so it asserts in the same cycle as o_valid. A frame already in flight is still received; if it completes while the previous byte is unread, it triggers an overrun.
- Latency: a falling edge on the pin reaches o_valid after SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1 for pin-edge phase.
- Reset mid-frame: the partial byte is abandoned and there are no pulses. The next frame is accepted only after a fresh falling edge.
- Frame error and overrun are mutually exclusive per frame. o_frame_err and o_new_frame never pulse in the same cycle.

Decomposition:
- Shared package trng_com_pkg:
  - RX state enum (IDLE, START, DATA, STOP).
  - Frame constants DATA_BITS=8 and STOP_BITS=1, shared with trng_com.
  - Function clog2 for timer width.
- One sub-module, trng_sync: parameterised SYNC_STAGES flop chain with a reset value of 1. It is reusable for i_serial_rts_n in trng_com.

Test Plan (CLKS_PER_BIT=8, SYNC_STAGES=2):
- Send byte 0xA5 with a good stop bit, i_read=0 → o_new_frame pulses once; o_dat=0xA5, o_valid=1 and o_serial_rts_n=1 from the same cycle; the valid edge falls within the computed latency ±1. Pulse i_read → o_valid=0 and rts_n=0 on the next cycle.
- Low glitch of 3 clocks on an idle line → no state escape beyond START; no pulses; o_valid stays 0.
- Byte 0x3C with stop bit held low, then line held low for 40 clocks, then high, then byte 0x81 → o_frame_err pulses once; no frame starts during the low period; 0x81 is received correctly.
- Bytes 0x11 then 0x22 back-to-back with no i_read → o_dat stays 0x11; o_overrun pulses once at the 0x22 stop; o_new_frame pulses once in total.
- Byte 0x55 pending, and i_read asserted exactly in the delivery cycle of the next byte 0xF0 → o_valid stays 1, o_dat=0xF0, no overrun.
- Assert i_reset during data bit 4 of 0xFF, release, then send 0x00 → no output from the aborted frame; 0x00 is delivered correctly; all outputs match their reset values during reset.
